// File: rtl/umi_merge_arbiter.sv
// umi_merge_arbiter: round-robin N:1 UMI arbiter that keeps a grant for whole messages in front of a merge engine
// Ports: clk, nreset (async, active-low); umi_in_{valid,cmd,dstaddr,srcaddr,data} per requester (packed i*W +: W),
// umi_in_ready per requester; umi_out_{valid,cmd,dstaddr,srcaddr,data} to the merge engine, umi_out_ready from it;
// umi_out_src is the index of the requester currently forwarded.
// Optional macro UMI_MERGE_ARB_HOLD_EN: keep the grant for up to MAXMSG back-to-back messages (HOLD state).
module umi_merge_arbiter #(
    parameter int N      = 4,
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int MAXMSG = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [N-1:0]         umi_in_valid,
    input  logic [N*CW-1:0]      umi_in_cmd,
    input  logic [N*AW-1:0]      umi_in_dstaddr,
    input  logic [N*AW-1:0]      umi_in_srcaddr,
    input  logic [N*DW-1:0]      umi_in_data,
    output logic [N-1:0]         umi_in_ready,
    output logic                 umi_out_valid,
    output logic [CW-1:0]        umi_out_cmd,
    output logic [AW-1:0]        umi_out_dstaddr,
    output logic [AW-1:0]        umi_out_srcaddr,
    output logic [DW-1:0]        umi_out_data,
    input  logic                 umi_out_ready,
    output logic [$clog2(N)-1:0] umi_out_src
);
    localparam int SW = $clog2(N);
    typedef enum logic [1:0] {IDLE, LOCK, HOLD} state_t;
    state_t        state;
    logic [SW-1:0] owner, ptr, arb, gnt, idx;
    logic          commit, eom;
    // Scan from farthest to nearest after ptr so the nearest valid requester wins.
    always_comb begin
        arb = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(ptr) + k) % N);
            if (umi_in_valid[idx]) arb = idx;
        end
    end
    assign gnt             = (state == LOCK || (state == HOLD && umi_in_valid[owner])) ? owner : arb;
    assign umi_out_valid   = umi_in_valid[gnt];
    assign umi_out_cmd     = umi_in_cmd[gnt*CW +: CW];
    assign umi_out_dstaddr = umi_in_dstaddr[gnt*AW +: AW];
    assign umi_out_srcaddr = umi_in_srcaddr[gnt*AW +: AW];
    assign umi_out_data    = umi_in_data[gnt*DW +: DW];
    assign umi_in_ready    = umi_out_ready ? N'(1) << gnt : '0;
    assign umi_out_src     = gnt;
    assign commit          = umi_out_valid & umi_out_ready;
    // Standard UMI command unpack places cmd_eom at bit 22.
    assign eom             = umi_out_cmd[22];
`ifdef UMI_MERGE_ARB_HOLD_EN
    localparam int MW = $clog2(MAXMSG + 1);
    logic [MW-1:0] msg_cnt, cnt_base, cnt_nxt;
    logic          more;
    // A new owner starts its message count from zero.
    assign cnt_base = (gnt != owner) ? '0 : msg_cnt;
    assign cnt_nxt  = cnt_base + MW'(1);
    assign more     = cnt_nxt < MW'(MAXMSG);
`endif
    // Any offered packet becomes the owner's; a stall or an unfinished message locks the grant.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= SW'(N - 1);
`ifdef UMI_MERGE_ARB_HOLD_EN
            msg_cnt <= '0;
`endif
        end else begin
            if (umi_out_valid) begin
                owner   <= gnt;
                ptr     <= gnt;
`ifdef UMI_MERGE_ARB_HOLD_EN
                msg_cnt <= cnt_base;
`endif
            end
            if (commit && eom) begin
`ifdef UMI_MERGE_ARB_HOLD_EN
                state   <= more ? HOLD : IDLE;
                msg_cnt <= more ? cnt_nxt : '0;
`else
                state   <= IDLE;
`endif
            end else if (umi_out_valid) begin
                state <= LOCK;
`ifdef UMI_MERGE_ARB_HOLD_EN
            end else if (state == HOLD && !(|umi_in_valid)) begin
                state   <= IDLE;
                msg_cnt <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_umi_merge_arbiter.sv
// tb_umi_merge_arbiter: scoreboard bench for umi_merge_arbiter (N=4, MAXMSG=4)
module tb_umi_merge_arbiter;
    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [CW-1:0] CMD_EOM = 32'h0040_0003;
    localparam logic [CW-1:0] CMD_MID = 32'h0000_0003;
    localparam logic [AW-1:0] DST_X   = 64'hA5A5_0000_0F0F_1234;
    typedef struct {logic [DW-1:0] d; logic eom;} pkt_t;
    typedef struct {int src; logic [DW-1:0] d;} exp_t;

    logic            clk = 0;
    logic            nreset = 0;
    logic [N-1:0]    umi_in_valid = '0;
    logic [N*CW-1:0] umi_in_cmd = '0;
    logic [N*AW-1:0] umi_in_dstaddr = '0;
    logic [N*AW-1:0] umi_in_srcaddr = '0;
    logic [N*DW-1:0] umi_in_data = '0;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready = 0;
    logic [1:0]      umi_out_src;

    pkt_t         rq[N][$];
    exp_t         sb[$];
    int           tx_cnt[N];
    int           ex_cnt[N];
    logic [N-1:0] fire = '0;
    int           checks = 0;
    int           fails = 0;

    umi_merge_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .MAXMSG(4)) dut (
        .clk(clk),
        .nreset(nreset),
        .umi_in_valid(umi_in_valid),
        .umi_in_cmd(umi_in_cmd),
        .umi_in_dstaddr(umi_in_dstaddr),
        .umi_in_srcaddr(umi_in_srcaddr),
        .umi_in_data(umi_in_data),
        .umi_in_ready(umi_in_ready),
        .umi_out_valid(umi_out_valid),
        .umi_out_cmd(umi_out_cmd),
        .umi_out_dstaddr(umi_out_dstaddr),
        .umi_out_srcaddr(umi_out_srcaddr),
        .umi_out_data(umi_out_data),
        .umi_out_ready(umi_out_ready),
        .umi_out_src(umi_out_src)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(int r, int n);
        return {8'(r), 24'h5A5A5A, 32'(n)};
    endfunction

    task automatic push_pkt(int r, logic eom);
        rq[r].push_back('{mk(r, tx_cnt[r]), eom});
        tx_cnt[r]++;
    endtask

    task automatic push_exp(int r);
        sb.push_back('{r, mk(r, ex_cnt[r])});
        ex_cnt[r]++;
    endtask

    // One clock: retire accepted packets and present queue heads after the edge,
    // then score any commit at the falling edge.
    task automatic step(input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        umi_out_ready = rdy;
        for (int i = 0; i < N; i++) begin
            if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            umi_in_valid[i] = rq[i].size() > 0;
            umi_in_cmd[i*CW +: CW]     = umi_in_valid[i] ? (rq[i][0].eom ? CMD_EOM : CMD_MID) : '0;
            umi_in_data[i*DW +: DW]    = umi_in_valid[i] ? rq[i][0].d : '0;
            umi_in_dstaddr[i*AW +: AW] = umi_in_valid[i] ? rq[i][0].d ^ DST_X : '0;
            umi_in_srcaddr[i*AW +: AW] = umi_in_valid[i] ? ~rq[i][0].d : '0;
        end
        @(negedge clk);
        fire = umi_in_valid & umi_in_ready;
        if (umi_out_valid && umi_out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: commit from src %0d data %h, required no commit", umi_out_src, umi_out_data);
            end else begin
                e = sb.pop_front();
                if (umi_out_src !== 2'(e.src) || umi_out_data !== e.d || umi_out_dstaddr !== (e.d ^ DST_X)
                    || umi_out_srcaddr !== ~e.d) begin
                    fails++;
                    $display("FAIL sb_order: got src %0d data %h, required src %0d data %h",
                             umi_out_src, umi_out_data, e.src, e.d);
                end
            end
        end
    endtask

    task automatic drain(output int bubbles);
        int budget = 200;
        bubbles = 0;
        while (sb.size() > 0 && budget > 0) begin
            step(1);
            if (!umi_out_valid) bubbles++;
            budget--;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d packets outstanding, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nreset = 0;
        umi_out_ready = 0;
        umi_in_valid = '0;
        fire = '0;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            tx_cnt[i] = 0;
            ex_cnt[i] = 0;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        nreset = 1;
    endtask

    task automatic test_reset();
        int b;
        @(negedge clk);
        checks++;
        if (umi_out_valid !== 1'b0 || umi_in_ready !== 4'b0000 || umi_out_src !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: valid %b ready %b src %0d, required 0 0000 0", umi_out_valid, umi_in_ready, umi_out_src);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (umi_out_valid !== 1'b0 || umi_in_ready !== 4'b0000 || umi_out_src !== 2'd0) begin
            fails++;
            $display("FAIL reset_idle: valid %b ready %b src %0d, required 0 0000 0", umi_out_valid, umi_in_ready, umi_out_src);
        end
        push_pkt(0, 1);
        push_pkt(2, 1);
        push_exp(0);
        push_exp(2);
        drain(b);
        checks++;
        if (b !== 0) begin
            fails++;
            $display("FAIL reset_bubbles: %0d, required 0", b);
        end
    endtask

    task automatic test_atomicity();
        int b;
        do_reset();
        push_pkt(1, 0);
        push_pkt(1, 0);
        push_pkt(1, 1);
        repeat (3) push_exp(1);
        step(1);
        push_pkt(0, 1);
        push_exp(0);
        step(1);
        checks++;
        if (umi_in_valid[0] !== 1'b1 || umi_out_src !== 2'd1) begin
            fails++;
            $display("FAIL atomic_lock: src %0d, required 1 with req 0 waiting", umi_out_src);
        end
        drain(b);
        checks++;
        if (b !== 0) begin
            fails++;
            $display("FAIL atomic_bubbles: %0d, required 0", b);
        end
    endtask

    task automatic test_stall();
        int b;
        do_reset();
        push_pkt(3, 1);
        push_exp(3);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) push_pkt(0, 1);
            step(0);
            checks++;
            if (umi_out_valid !== 1'b1 || umi_out_src !== 2'd3 || umi_out_data !== mk(3, 0) || umi_in_ready !== 4'b0000) begin
                fails++;
                $display("FAIL stall_freeze_c%0d: valid %b src %0d data %h ready %b, required 1 3 %h 0000",
                         c, umi_out_valid, umi_out_src, umi_out_data, umi_in_ready, mk(3, 0));
            end
        end
        push_exp(0);
        drain(b);
        checks++;
        if (b !== 0) begin
            fails++;
            $display("FAIL stall_bubbles: %0d, required 0", b);
        end
    endtask

    task automatic test_hold();
        int b;
        int order[8];
`ifdef UMI_MERGE_ARB_HOLD_EN
        order = '{2, 2, 2, 2, 1, 1, 2, 2};
`else
        order = '{2, 1, 2, 1, 2, 2, 2, 2};
`endif
        do_reset();
        repeat (6) push_pkt(2, 1);
        push_exp(order[0]);
        step(1);
        push_pkt(1, 1);
        push_pkt(1, 1);
        for (int k = 1; k < 8; k++) push_exp(order[k]);
        drain(b);
        checks++;
        if (b !== 0) begin
            fails++;
            $display("FAIL hold_bubbles: %0d, required 0", b);
        end
    endtask

    task automatic test_hold_fallback();
        int b;
        int order[7];
`ifdef UMI_MERGE_ARB_HOLD_EN
        order = '{2, 0, 0, 0, 0, 1, 0};
`else
        order = '{2, 0, 1, 0, 0, 0, 0};
`endif
        do_reset();
        push_pkt(2, 1);
        push_exp(order[0]);
        step(1);
        repeat (5) push_pkt(0, 1);
        push_pkt(1, 1);
        for (int k = 1; k < 7; k++) push_exp(order[k]);
        step(1);
        checks++;
        if (umi_out_valid !== 1'b1 || umi_out_src !== 2'd0) begin
            fails++;
            $display("FAIL fallback_same_cycle: valid %b src %0d, required 1 0", umi_out_valid, umi_out_src);
        end
        drain(b);
        checks++;
        if (b !== 0) begin
            fails++;
            $display("FAIL fallback_bubbles: %0d, required 0", b);
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        push_pkt(1, 0);
        push_pkt(1, 0);
        push_pkt(1, 1);
        push_exp(1);
        step(1);
        push_pkt(0, 1);
        step(0);
        checks++;
        if (umi_out_src !== 2'd1 || umi_out_data !== mk(1, 1)) begin
            fails++;
            $display("FAIL midmsg_lock: src %0d data %h, required 1 %h", umi_out_src, umi_out_data, mk(1, 1));
        end
        nreset = 0;
        #1;
        checks++;
        if (umi_out_valid !== 1'b1 || umi_out_src !== 2'd0 || umi_out_data !== mk(0, 0)) begin
            fails++;
            $display("FAIL midmsg_reset: valid %b src %0d data %h, required 1 0 %h",
                     umi_out_valid, umi_out_src, umi_out_data, mk(0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_atomicity();
        test_stall();
        test_hold();
        test_hold_fallback();
        test_reset_mid_message();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
